uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/sylap_cmd_pkg.sv | 28 ++
 rtl/cmd_timeout_ctr.sv | 37 +++
 rtl/uart_cmd_parser.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sylap_cmd_pkg.sv
// +--------------------------------------------------------------------+
// | sylap_cmd_pkg: state encoding and frame constants for the UART     |
// | command parser.                          Rev 1.0 - initial release |
// +--------------------------------------------------------------------+
`default_nettype none

package sylap_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_COMMIT = 3'd4
  } cmd_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         DATA_BYTES        = 4;
  localparam int         FRAME_LEN_NOCHK   = 2 + DATA_BYTES;
  localparam int         FRAME_LEN_CHK     = FRAME_LEN_NOCHK + 1;

  function automatic logic [7:0] frame_xor(input logic [7:0] addr, input logic [31:0] data);
    return addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_timeout_ctr.sv
// +--------------------------------------------------------------------+
// | cmd_timeout_ctr: saturating inter-byte cycle counter with clear,   |
// | enable and terminal-count output.        Rev 1.0 - initial release |
// +--------------------------------------------------------------------+
`default_nettype none

module cmd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int             W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0]   TC = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  assign o_tc = (r_count == TC);

  // Holding at the terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// +--------------------------------------------------------------------+
// | uart_cmd_parser: turns SYNC/ADDR/D3..D0[/CHK] byte frames into     |
// | register writes. Checksum byte enabled by UART_CMD_CHECKSUM_EN.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_cmd_parser
  import sylap_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err_chk,
  output logic        err_timeout,
  output logic        busy
);

  localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);

  cmd_state_t  r_state;
  logic        r_arm;
  logic [7:0]  r_addr_sh;
  logic [31:0] r_data_sh;
  logic [1:0]  r_idx;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_err_to;
  logic        r_busy;

  logic w_rx;
  logic w_tc;
  logic w_cnt_en;
  logic w_cnt_clr;

  // The first cycle out of reset ignores rx_rdy.
  assign w_rx      = rx_rdy & r_arm;
  assign w_cnt_en  = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_cnt_clr = w_rx || !w_cnt_en;

  cmd_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_tc     (w_tc)
  );

`ifdef UART_CMD_CHECKSUM_EN
  logic       r_err_chk;
  logic [7:0] w_xor;
  assign w_xor   = frame_xor(r_addr_sh, r_data_sh);
  assign err_chk = r_err_chk;
`else
  assign err_chk = 1'b0;
`endif

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign err_timeout = r_err_to;
  assign busy        = r_busy;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_arm     <= 1'b0;
      r_addr_sh <= 8'h00;
      r_data_sh <= 32'h0;
      r_idx     <= 2'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 32'h0;
      r_err_to  <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      r_err_chk <= 1'b0;
`endif
    end else begin
      r_arm    <= 1'b1;
      r_wr_en  <= 1'b0;
      r_err_to <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      r_err_chk <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_rx && (rx_data == SYNC_BYTE)) begin
            r_state <= ST_ADDR;
            r_busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (w_rx) begin
            r_addr_sh <= rx_data;
            r_idx     <= 2'd0;
            r_state   <= ST_DATA;
          end else if (w_tc) begin
            r_err_to <= 1'b1;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_rx) begin
            r_data_sh <= {r_data_sh[23:0], rx_data};
            r_idx     <= r_idx + 2'd1;
            if (r_idx == LAST_IDX) begin
`ifdef UART_CMD_CHECKSUM_EN
              r_state <= ST_CHK;
`else
              r_state <= ST_COMMIT;
`endif
            end
          end else if (w_tc) begin
            r_err_to <= 1'b1;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        ST_CHK: begin
          if (w_rx) begin
            if (rx_data == w_xor) begin
              r_state <= ST_COMMIT;
            end else begin
              r_err_chk <= 1'b1;
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
            end
          end else if (w_tc) begin
            r_err_to <= 1'b1;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
        end
`endif
        ST_COMMIT: begin
          r_wr_addr <= r_addr_sh;
          r_wr_data <= r_data_sh;
          r_wr_en   <= 1'b1;
          // A SYNC byte landing on the commit cycle starts the next frame.
          if (w_rx && (rx_data == SYNC_BYTE)) begin
            r_state <= ST_ADDR;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
